camera_stream_tx: RTL and testbench
===================================

CAMERA_STREAM_TX -- requirements
Module: camera_stream_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 128, giving bytes (pixel periods) per active line; SHALL be a multiple of 4.
REQ-002 SHALL have parameter V_ACTIVE, default 64, giving the number of active lines; H_ACTIVE*V_ACTIVE SHALL NOT exceed 8192.
REQ-003 SHALL have parameter H_BLANK, default 16, giving pixel periods per line with href low.
REQ-004 SHALL have parameters VSYNC_LEN, V_BP and V_FP, defaults 3, 2 and 2, giving line counts of the vsync, back-porch and front-porch regions.
REQ-005 wb_clk_i  in  1  system and pixel-timing clock; all logic on its rising edge.
REQ-006 rstb  in  1  asynchronous, active-low reset.
REQ-007 wb_adr_i  in  14 [15:2]  word address; wb_dat_i  in  32  write data; wb_dat_o  out  32  read data.
REQ-008 wb_we_i, wb_stb_i, wb_cyc_i  in  1  Wishbone controls; wb_ack_o  out  1  acknowledge.
REQ-009 wb_inta_o  out  1  one-cycle active-high frame-done pulse.
REQ-010 tx_pclk, tx_vsync, tx_href  out  1  camera-style stream strobes; tx_data  out  8  pixel byte.

Function
REQ-011 wb_ack_o SHALL rise one cycle after wb_cyc_i&wb_stb_i with wb_ack_o low, then drop for one cycle, so every access takes two cycles.
REQ-012 adr[15]=0, adr[2]=0: CTRL, read/write; bit0 ENABLE, bit1 PATTERN; other bits read 0.
REQ-013 adr[15]=0, adr[2]=1: STATUS, read-only; bit0 BUSY (FSM not IDLE), bits[31:16] FRAME_CNT; writes ignored.
REQ-014 adr[15]=1: frame buffer, 2048 x 32 words at adr[12:2]; write-only; reads return 0; writes take effect immediately, including during streaming (no tear protection).
REQ-015 Pixel period SHALL be 2 wb_clk_i cycles: tx_pclk low in the first cycle, high in the second; tx_vsync, tx_href and tx_data SHALL change only at the period start (tx_pclk falling).
REQ-016 FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP; every non-IDLE line lasts H_ACTIVE+H_BLANK pixel periods.
REQ-017 IDLE->VSYNC at the first period boundary with ENABLE=1; tx_vsync SHALL be high within 4 wb_clk_i cycles of the CTRL write ack.
REQ-018 VSYNC (VSYNC_LEN lines, tx_vsync=1) -> VBP (V_BP lines) -> ACTIVE (V_ACTIVE lines) -> VFP (V_FP lines); at the end of VFP -> VSYNC if ENABLE=1, else IDLE.
REQ-019 In ACTIVE, tx_href SHALL be 1 for pixel periods 0..H_ACTIVE-1 of each line and 0 in blanking; tx_href SHALL be 0 in all other states.
REQ-020 The byte at address b=line*H_ACTIVE+px SHALL be taken from word b>>2, lane b[1:0], with lane 0 = bits[31:24] (MSB byte first).
REQ-021 tx_data SHALL be 0 whenever tx_href=0.
REQ-022 Clearing ENABLE mid-frame SHALL NOT truncate the frame; the stream stops only at the end of VFP.
REQ-023 At the end of each VFP, FRAME_CNT SHALL increment (16-bit, wraps 0xFFFF->0) and wb_inta_o SHALL pulse for exactly one cycle.
REQ-024 On a same-cycle bus write and stream read of the same word, the stream SHALL get the old data (read-first).
REQ-025 tx_pclk SHALL be held low in IDLE.

Reset
REQ-026 rstb low SHALL asynchronously force: all tx_* = 0, wb_ack_o = 0, wb_inta_o = 0, CTRL = 0, FRAME_CNT = 0, FSM = IDLE, counters = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no inta pulse; frame buffer contents are not reset.
REQ-028 After rstb rises, no stream activity SHALL occur until ENABLE is written to 1.

Configuration
REQ-029 Macro CAMERA_TX_PATTERN_EN: when defined, PATTERN=1 SHALL replace buffer data with (px[7:0] XOR line[7:0]) during href, where line counts active lines from 0.
REQ-030 When CAMERA_TX_PATTERN_EN is undefined, CTRL bit1 SHALL read 0, writes to it SHALL be ignored, and no pattern logic SHALL be present.

Verification
REQ-031 Reset: hold rstb low -> all outputs 0; CTRL and STATUS read 0x00000000.
REQ-032 Write buffer word 0 = 0x11223344, word 1 = 0xA5A5A5A5, CTRL=1 -> first active line yields tx_data 11,22,33,44,A5,A5,A5,A5 on successive tx_pclk rising edges with tx_href=1.
REQ-033 Defaults, ENABLE=1 -> tx_vsync high for 3*144*2 = 864 cycles; 64 href pulses per frame of 128 rising pclk each; frame = 71*144*2 = 20448 cycles.
REQ-034 Clear ENABLE during ACTIVE line 10 -> frame completes, FRAME_CNT +1, one wb_inta_o pulse, then BUSY=0 and tx_pclk stays low.
REQ-035 Assert rstb mid active line -> tx_href/tx_data/tx_pclk drop to 0 asynchronously, no inta pulse, FRAME_CNT reads 0.
REQ-036 With macro, CTRL=3 -> line 2, px 5 gives tx_data 0x07; without macro, CTRL write 3 reads back 0x00000001 and buffer data streams.

Source files
------------

// File: rtl/camera_stream_tx.sv
// camera_stream_tx: Wishbone-loaded 2048x32 frame buffer streamed out as camera-style pclk/vsync/href/data.
// Optional macro CAMERA_TX_PATTERN_EN adds CTRL.PATTERN, which replaces buffer bytes with px^line.
module camera_stream_tx #(
   parameter int H_ACTIVE  = 128,
   parameter int V_ACTIVE  = 64,
   parameter int H_BLANK   = 16,
   parameter int VSYNC_LEN = 3,
   parameter int V_BP      = 2,
   parameter int V_FP      = 2
) (
   input  logic        wb_clk_i,
   input  logic        rstb,
   input  logic [15:2] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        wb_inta_o,
   output logic        tx_pclk,
   output logic        tx_vsync,
   output logic        tx_href,
   output logic [7:0]  tx_data
);
   localparam int H_TOT = H_ACTIVE + H_BLANK;
   localparam int PXW   = $clog2(H_TOT);
   localparam int LNW   = 16;

   typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

   state_t         st, st_n;
   logic [PXW-1:0] px, px_n;
   logic [LNW-1:0] ln, ln_n;
   logic           ph, tick, line_end, last_line, done;
   logic           ctrl_en, ctrl_pat;
   logic [15:0]    frame_cnt;
   logic           req;
   logic [31:0]    rd_n;
   logic [31:0]    mem [0:2047];
   logic [12:0]    b_n;
   logic [31:0]    word_n;
   logic           href_n, vsync_n;
   logic [7:0]     data_n;
   logic           unused_adr;

   assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign unused_adr = ^wb_adr_i[14:13];
   assign tx_pclk    = ph;

   // register-file read mux: CTRL, STATUS, buffer reads as zero
   always_comb
      rd_n = wb_adr_i[15] ? 32'h0 :
             wb_adr_i[2]  ? {frame_cnt, 15'h0, st != IDLE} :
                            {30'h0, ctrl_pat, ctrl_en};

`ifdef CAMERA_TX_PATTERN_EN
   // two-cycle bus handshake, read capture and CTRL writes (with PATTERN bit)
   always_ff @(posedge wb_clk_i or negedge rstb)
      if (!rstb) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         ctrl_en  <= 1'b0;
         ctrl_pat <= 1'b0;
      end else begin
         wb_ack_o <= req;
         if (req) wb_dat_o <= rd_n;
         if (req && wb_we_i && !wb_adr_i[15] && !wb_adr_i[2]) begin
            ctrl_en  <= wb_dat_i[0];
            ctrl_pat <= wb_dat_i[1];
         end
      end
`else
   assign ctrl_pat = 1'b0;

   // two-cycle bus handshake, read capture and CTRL writes
   always_ff @(posedge wb_clk_i or negedge rstb)
      if (!rstb) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         ctrl_en  <= 1'b0;
      end else begin
         wb_ack_o <= req;
         if (req) wb_dat_o <= rd_n;
         if (req && wb_we_i && !wb_adr_i[15] && !wb_adr_i[2]) ctrl_en <= wb_dat_i[0];
      end
`endif

   // frame buffer write port; contents deliberately survive reset
   always_ff @(posedge wb_clk_i)
      if (req && wb_we_i && wb_adr_i[15]) mem[wb_adr_i[12:2]] <= wb_dat_i;

   // FSM state, pixel/line counters and pixel-period phase
   always_ff @(posedge wb_clk_i or negedge rstb)
      if (!rstb) begin
         st <= IDLE;
         px <= '0;
         ln <= '0;
         ph <= 1'b0;
      end else begin
         st <= st_n;
         px <= px_n;
         ln <= ln_n;
         ph <= (st != IDLE) ? ~ph : 1'b0;
      end

   // next state: advance at the end of each pixel period, every cycle while idle
   always_comb begin
      tick      = (st == IDLE) | ph;
      line_end  = px == PXW'(H_TOT - 1);
      last_line = (st == VSYNC)  ? ln == LNW'(VSYNC_LEN - 1) :
                  (st == VBP)    ? ln == LNW'(V_BP - 1) :
                  (st == ACTIVE) ? ln == LNW'(V_ACTIVE - 1) :
                  (st == VFP)    ? ln == LNW'(V_FP - 1) : 1'b0;
      st_n = st;
      px_n = px;
      ln_n = ln;
      if (tick && st == IDLE) begin
         st_n = ctrl_en ? VSYNC : IDLE;
         px_n = '0;
         ln_n = '0;
      end else if (tick) begin
         px_n = line_end ? '0 : px + 1'b1;
         ln_n = !line_end ? ln : last_line ? '0 : ln + 1'b1;
         if (line_end && last_line)
            st_n = (st == VSYNC)  ? VBP :
                   (st == VBP)    ? ACTIVE :
                   (st == ACTIVE) ? VFP :
                   ctrl_en        ? VSYNC : IDLE;
      end
      done = tick && st == VFP && line_end && last_line;
   end

   // outputs for the upcoming pixel period, buffer read-before-write
   always_comb begin
      b_n     = 13'(ln_n) * 13'(H_ACTIVE) + 13'(px_n);
      word_n  = mem[b_n[12:2]];
      href_n  = (st_n == ACTIVE) && (px_n < PXW'(H_ACTIVE));
      vsync_n = st_n == VSYNC;
`ifdef CAMERA_TX_PATTERN_EN
      data_n  = !href_n  ? 8'h00 :
                ctrl_pat ? 8'(px_n) ^ 8'(ln_n) :
                           8'(word_n >> {~b_n[1:0], 3'b000});
`else
      data_n  = href_n ? 8'(word_n >> {~b_n[1:0], 3'b000}) : 8'h00;
`endif
   end

   // stream strobes update only at period start; frame-done pulse and counter
   always_ff @(posedge wb_clk_i or negedge rstb)
      if (!rstb) begin
         tx_vsync  <= 1'b0;
         tx_href   <= 1'b0;
         tx_data   <= 8'h00;
         wb_inta_o <= 1'b0;
         frame_cnt <= 16'h0;
      end else begin
         wb_inta_o <= done;
         if (done) frame_cnt <= frame_cnt + 1'b1;
         if (tick) begin
            tx_vsync <= vsync_n;
            tx_href  <= href_n;
            tx_data  <= data_n;
         end
      end
endmodule

// File: tb/tb_camera_stream_tx.sv
// tb_camera_stream_tx: directed self-checking bench for camera_stream_tx at default geometry
module tb_camera_stream_tx;
   logic        wb_clk_i = 1'b0;
   logic        rstb = 1'b0;
   logic [15:2] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
   logic        wb_ack_o, wb_inta_o;
   logic        tx_pclk, tx_vsync, tx_href;
   logic [7:0]  tx_data;

   int checks = 0;
   int failures = 0;

   camera_stream_tx dut (
      .wb_clk_i(wb_clk_i), .rstb(rstb), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_ack_o(wb_ack_o), .wb_inta_o(wb_inta_o), .tx_pclk(tx_pclk), .tx_vsync(tx_vsync),
      .tx_href(tx_href), .tx_data(tx_data)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      repeat (150000) @(posedge wb_clk_i);
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1);
   end

   task automatic wb_access(input logic we, input logic [15:0] a, input logic [31:0] d, output logic [31:0] q);
      int n = 0;
      @(posedge wb_clk_i); #1;
      wb_adr_i = a[15:2]; wb_dat_i = d; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      do begin @(posedge wb_clk_i); #1; n++; end while (!wb_ack_o && n < 8);
      q = wb_dat_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      checks++;
      if (n != 1 || !wb_ack_o) begin
         failures++;
         $display("FAIL wb_ack adr=%h: ack after %0d cycles (ack=%b), required 1 cycle", a, n, wb_ack_o);
      end
   endtask

   task automatic wb_write(input logic [15:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_access(1'b1, a, d, q);
   endtask

   task automatic wb_read(input logic [15:0] a, output logic [31:0] q);
      wb_access(1'b0, a, 32'h0, q);
   endtask

   task automatic test_reset;
      logic [31:0] q;
      int p = 0;
      rstb = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      checks += 7;
      if (tx_pclk !== 1'b0)  begin failures++; $display("FAIL rst_pclk: got %b, required 0", tx_pclk); end
      if (tx_vsync !== 1'b0) begin failures++; $display("FAIL rst_vsync: got %b, required 0", tx_vsync); end
      if (tx_href !== 1'b0)  begin failures++; $display("FAIL rst_href: got %b, required 0", tx_href); end
      if (tx_data !== 8'h0)  begin failures++; $display("FAIL rst_data: got %h, required 00", tx_data); end
      if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b, required 0", wb_ack_o); end
      if (wb_inta_o !== 1'b0) begin failures++; $display("FAIL rst_inta: got %b, required 0", wb_inta_o); end
      if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat: got %h, required 0", wb_dat_o); end
      rstb = 1'b1;
      wb_read(16'h0000, q);
      checks++;
      if (q !== 32'h0) begin failures++; $display("FAIL rst_ctrl: got %h, required 00000000", q); end
      wb_read(16'h0004, q);
      checks++;
      if (q !== 32'h0) begin failures++; $display("FAIL rst_status: got %h, required 00000000", q); end
      wb_write(16'h0004, 32'hFFFF_FFFF);
      wb_read(16'h0004, q);
      checks++;
      if (q !== 32'h0) begin failures++; $display("FAIL status_ro: got %h, required 00000000", q); end
      wb_write(16'h8014, 32'hDEAD_BEEF);
      wb_read(16'h8014, q);
      checks++;
      if (q !== 32'h0) begin failures++; $display("FAIL buf_read: got %h, required 00000000", q); end
      repeat (50) begin @(negedge wb_clk_i); p += tx_pclk | tx_vsync; end
      checks++;
      if (p != 0) begin failures++; $display("FAIL idle_quiet: %0d active cycles, required 0", p); end
   endtask

   task automatic test_stream_data;
      logic [7:0] exp_b [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
      logic [7:0] got_b [8];
      int got = 0, n = 0;
      wb_write(16'h8000, 32'h1122_3344);
      wb_write(16'h8004, 32'hA5A5_A5A5);
      wb_write(16'h0000, 32'h0000_0001);
      while (!tx_vsync && n < 4) begin @(posedge wb_clk_i); #1; n++; end
      checks++;
      if (tx_vsync !== 1'b1) begin failures++; $display("FAIL vsync_latency: vsync=%b after %0d cycles, required 1 within 4", tx_vsync, n); end
      @(negedge wb_clk_i);
      checks++;
      if (tx_href !== 1'b0 || tx_data !== 8'h0) begin failures++; $display("FAIL vsync_quiet: href=%b data=%h, required 0/00", tx_href, tx_data); end
      n = 0;
      while (got < 8 && n < 4000) begin
         @(negedge wb_clk_i); n++;
         if (tx_href && tx_pclk) begin got_b[got] = tx_data; got++; end
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= got || got_b[i] !== exp_b[i]) begin
            failures++; $display("FAIL line0_byte%0d: got %h (collected %0d), required %h", i, got_b[i], got, exp_b[i]);
         end
      end
      n = 0;
      while (tx_href && n < 600) begin @(negedge wb_clk_i); n++; end
      checks++;
      if (tx_href !== 1'b0 || tx_data !== 8'h0) begin failures++; $display("FAIL blank_data: href=%b data=%h, required 0/00", tx_href, tx_data); end
   endtask

   task automatic test_frame_timing;
      logic prev, hprev;
      logic [31:0] q;
      int n = 0, len = 0, vs = 1, pulses = 0, pix = 0, ints = 0;
      prev = tx_vsync;
      while (n < 25000) begin
         @(negedge wb_clk_i); n++;
         if (tx_vsync && !prev) break;
         prev = tx_vsync;
      end
      checks++;
      if (n >= 25000) begin failures++; $display("FAIL frame_start: no vsync rise in %0d cycles, required one", n); end
      prev = 1'b1; hprev = tx_href;
      while (len < 25000) begin
         @(negedge wb_clk_i); len++;
         ints += wb_inta_o;
         if (tx_vsync && !prev) break;
         vs += tx_vsync;
         pulses += (tx_href && !hprev);
         pix += (tx_href && tx_pclk);
         prev = tx_vsync; hprev = tx_href;
      end
      checks += 5;
      if (len != 20448) begin failures++; $display("FAIL frame_len: got %0d cycles, required 20448", len); end
      if (vs != 864)    begin failures++; $display("FAIL vsync_len: got %0d cycles, required 864", vs); end
      if (pulses != 64) begin failures++; $display("FAIL href_pulses: got %0d, required 64", pulses); end
      if (pix != 8192)  begin failures++; $display("FAIL href_pixels: got %0d, required 8192", pix); end
      if (ints != 1)    begin failures++; $display("FAIL frame_inta: got %0d pulse cycles, required 1", ints); end
      wb_read(16'h0004, q);
      checks++;
      if (q !== 32'h0002_0001) begin failures++; $display("FAIL status_run: got %h, required 00020001", q); end
   endtask

   task automatic test_disable_mid_frame;
      logic prev, hprev;
      logic [31:0] q;
      int n = 0, rises = 0, ints = 0, vr = 0, pcl = 0;
      hprev = tx_href;
      while (rises < 11 && n < 25000) begin
         @(negedge wb_clk_i); n++;
         rises += (tx_href && !hprev);
         hprev = tx_href;
      end
      wb_write(16'h0000, 32'h0);
      n = 0; prev = tx_vsync;
      while (ints == 0 && n < 25000) begin
         @(negedge wb_clk_i); n++;
         ints += wb_inta_o;
         vr += (tx_vsync && !prev);
         prev = tx_vsync;
      end
      checks++;
      if (ints == 0) begin failures++; $display("FAIL disable_inta: no inta in %0d cycles, required one", n); end
      repeat (600) begin
         @(negedge wb_clk_i);
         ints += wb_inta_o;
         vr += (tx_vsync && !prev);
         pcl += tx_pclk;
         prev = tx_vsync;
      end
      checks += 3;
      if (ints != 1) begin failures++; $display("FAIL disable_inta_cnt: got %0d pulse cycles, required 1", ints); end
      if (vr != 0)   begin failures++; $display("FAIL disable_restart: got %0d vsync rises, required 0", vr); end
      if (pcl != 0)  begin failures++; $display("FAIL disable_pclk: got %0d pclk-high cycles, required 0", pcl); end
      wb_read(16'h0004, q);
      checks++;
      if (q !== 32'h0003_0000) begin failures++; $display("FAIL disable_status: got %h, required 00030000", q); end
   endtask

   task automatic test_reset_mid_frame;
      logic [31:0] q;
      int n = 0, ints = 0, act = 0;
      wb_write(16'h0000, 32'h1);
      while (!tx_href && n < 3000) begin @(negedge wb_clk_i); n++; end
      repeat (3) @(negedge wb_clk_i);
      checks++;
      if (tx_href !== 1'b1) begin failures++; $display("FAIL pre_reset_href: got %b, required 1", tx_href); end
      #2 rstb = 1'b0;
      #1;
      checks += 5;
      if (tx_href !== 1'b0)  begin failures++; $display("FAIL async_href: got %b, required 0", tx_href); end
      if (tx_data !== 8'h0)  begin failures++; $display("FAIL async_data: got %h, required 00", tx_data); end
      if (tx_pclk !== 1'b0)  begin failures++; $display("FAIL async_pclk: got %b, required 0", tx_pclk); end
      if (tx_vsync !== 1'b0) begin failures++; $display("FAIL async_vsync: got %b, required 0", tx_vsync); end
      if (wb_inta_o !== 1'b0) begin failures++; $display("FAIL async_inta: got %b, required 0", wb_inta_o); end
      repeat (3) begin @(negedge wb_clk_i); ints += wb_inta_o; end
      rstb = 1'b1;
      repeat (2) begin @(negedge wb_clk_i); ints += wb_inta_o; end
      checks++;
      if (ints != 0) begin failures++; $display("FAIL reset_inta: got %0d pulse cycles, required 0", ints); end
      wb_read(16'h0004, q);
      checks++;
      if (q !== 32'h0) begin failures++; $display("FAIL reset_status: got %h, required 00000000", q); end
      wb_read(16'h0000, q);
      checks++;
      if (q !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h, required 00000000", q); end
      repeat (200) begin @(negedge wb_clk_i); act += tx_pclk | tx_vsync; end
      checks++;
      if (act != 0) begin failures++; $display("FAIL post_reset_quiet: %0d active cycles, required 0", act); end
   endtask

   task automatic test_pattern;
      logic [31:0] q;
      logic hprev;
      int n = 0, got = 0, rises = 0;
      logic [7:0] b [8];
      wb_write(16'h0000, 32'h3);
      wb_read(16'h0000, q);
      checks++;
`ifdef CAMERA_TX_PATTERN_EN
      if (q !== 32'h3) begin failures++; $display("FAIL ctrl_pattern: got %h, required 00000003", q); end
      hprev = tx_href;
      while (got < 6 && n < 6000) begin
         @(negedge wb_clk_i); n++;
         rises += (tx_href && !hprev);
         hprev = tx_href;
         if (rises == 3 && tx_href && tx_pclk) begin b[got] = tx_data; got++; end
      end
      checks++;
      if (got < 6 || b[5] !== 8'h07) begin failures++; $display("FAIL pattern_l2p5: got %h (collected %0d), required 07", b[5], got); end
`else
      if (q !== 32'h1) begin failures++; $display("FAIL ctrl_pattern: got %h, required 00000001", q); end
      hprev = tx_href;
      while (got < 4 && n < 4000) begin
         @(negedge wb_clk_i); n++;
         if (tx_href && tx_pclk) begin b[got] = tx_data; got++; end
      end
      checks++;
      if (got < 4 || {b[0], b[1], b[2], b[3]} !== 32'h1122_3344) begin
         failures++; $display("FAIL nopattern_data: got %h%h%h%h (collected %0d), required 11223344", b[0], b[1], b[2], b[3], got);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_stream_data;
      test_frame_timing;
      test_disable_mid_frame;
      test_reset_mid_frame;
      test_pattern;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
